// File: rtl/absorb_if.sv
// Handshake and control bundle between the SHAKE absorb controller and its surroundings:
// the message source, the padding/state-XOR path and the permutation core.
interface absorb_if #(
  parameter int LEN_WIDTH = 32,
  parameter int RVB_WIDTH = 4
);
  logic                 start_i;
  logic                 mode_i;
  logic [LEN_WIDTH-1:0] msg_len_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic                 word_valid_o;
  logic                 word_ready_i;
  logic [RVB_WIDTH-1:0] remaining_valid_bytes_o;
  logic                 padding_enable_o;
  logic                 last_word_in_block_o;
  logic                 padding_reset_o;
  logic                 perm_start_o;
  logic                 perm_done_i;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output start_i, mode_i, msg_len_i, in_valid_i, word_ready_i, perm_done_i,
    input  in_ready_o, word_valid_o, remaining_valid_bytes_o, padding_enable_o,
           last_word_in_block_o, padding_reset_o, perm_start_o, busy_o, done_o
  );

  modport slave (
    input  start_i, mode_i, msg_len_i, in_valid_i, word_ready_i, perm_done_i,
    output in_ready_o, word_valid_o, remaining_valid_bytes_o, padding_enable_o,
           last_word_in_block_o, padding_reset_o, perm_start_o, busy_o, done_o
  );
endinterface

// File: rtl/absorb_controller.sv
// SHAKE absorb sequencer: walks a byte-length message through the padding generator one
// 64-bit word at a time, counts words per rate block and triggers the Keccak permutation.
//
//   state     | meaning
//   S_IDLE    | waiting for start_i
//   S_ABSORB  | presenting message / padding words to the state-XOR path
//   S_PERMUTE | block handed to the permutation, waiting for perm_done_i
//   S_FINISH  | final block permuted, one-cycle done_o
module absorb_controller #(
  parameter int LEN_WIDTH     = 32,
  parameter int RATE128_WORDS = 21,
  parameter int RATE256_WORDS = 17,
  parameter int W_BYTE_SIZE   = 8
) (
  input logic     clk,
  input logic     rst_n,
  absorb_if.slave bus
);

  localparam int W_BYTE_WIDTH = $clog2(W_BYTE_SIZE);
  localparam int RVB_W        = W_BYTE_WIDTH + 1;
  localparam int MAX_RATE     = (RATE128_WORDS > RATE256_WORDS) ? RATE128_WORDS : RATE256_WORDS;
  localparam int CNT_W        = $clog2(MAX_RATE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ABSORB,
    S_PERMUTE,
    S_FINISH
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0] r_rem, w_rem_nxt;
  logic [CNT_W-1:0]     r_word_cnt, w_word_cnt_nxt;
  logic                 r_rate_sel, w_rate_sel_nxt;
  logic                 r_pad_started, w_pad_started_nxt;

  logic                 w_need_input;
  logic                 w_short;
  logic [RVB_W-1:0]     w_rvb;
  logic [CNT_W-1:0]     w_last_idx;
  logic                 w_last;
  logic                 w_word_valid;
  logic                 w_in_ready;
  logic                 w_pad_en;
  logic                 w_last_out;
  logic [RVB_W-1:0]     w_rvb_out;
  logic                 w_perm_start;
  logic                 w_done;

  assign w_need_input = (r_rem != '0);
  assign w_short      = (r_rem < LEN_WIDTH'(W_BYTE_SIZE));
  assign w_rvb        = w_short ? r_rem[RVB_W-1:0] : RVB_W'(W_BYTE_SIZE);
  assign w_last_idx   = r_rate_sel ? CNT_W'(RATE256_WORDS - 1) : CNT_W'(RATE128_WORDS - 1);
  assign w_last       = (r_word_cnt == w_last_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rem         <= '0;
      r_word_cnt    <= '0;
      r_rate_sel    <= 1'b0;
      r_pad_started <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rem         <= w_rem_nxt;
      r_word_cnt    <= w_word_cnt_nxt;
      r_rate_sel    <= w_rate_sel_nxt;
      r_pad_started <= w_pad_started_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_rem_nxt         = r_rem;
    w_word_cnt_nxt    = r_word_cnt;
    w_rate_sel_nxt    = r_rate_sel;
    w_pad_started_nxt = r_pad_started;
    w_word_valid      = 1'b0;
    w_in_ready        = 1'b0;
    w_pad_en          = 1'b0;
    w_last_out        = 1'b0;
    w_rvb_out         = '0;
    w_perm_start      = 1'b0;
    w_done            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt       = S_ABSORB;
          w_rem_nxt         = bus.msg_len_i;
          w_rate_sel_nxt    = bus.mode_i;
          w_word_cnt_nxt    = '0;
          w_pad_started_nxt = 1'b0;
        end
      end
      S_ABSORB: begin
        // Once the message is exhausted, padding words are emitted without waiting on input.
        w_word_valid = w_need_input ? bus.in_valid_i : 1'b1;
        w_in_ready   = w_need_input & bus.word_ready_i;
        w_pad_en     = w_short;
        w_last_out   = w_last;
        w_rvb_out    = w_rvb;
        if (w_word_valid && bus.word_ready_i) begin
          w_rem_nxt = r_rem - LEN_WIDTH'(w_rvb);
          if (w_short) w_pad_started_nxt = 1'b1;
          if (w_last) begin
            w_word_cnt_nxt = '0;
            w_perm_start   = 1'b1;
            w_state_nxt    = S_PERMUTE;
          end else begin
            w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
          end
        end
      end
      S_PERMUTE: begin
        if (bus.perm_done_i) w_state_nxt = r_pad_started ? S_FINISH : S_ABSORB;
      end
      S_FINISH: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so a mid-message abort is visible at once.
  assign bus.word_valid_o            = rst_n & w_word_valid;
  assign bus.in_ready_o              = rst_n & w_in_ready;
  assign bus.padding_enable_o        = rst_n & w_pad_en;
  assign bus.last_word_in_block_o    = rst_n & w_last_out;
  assign bus.remaining_valid_bytes_o = rst_n ? w_rvb_out : '0;
  assign bus.perm_start_o            = rst_n & w_perm_start;
  assign bus.done_o                  = rst_n & w_done;
  assign bus.busy_o                  = rst_n & (r_state != S_IDLE);
  assign bus.padding_reset_o         = !rst_n | ((r_state == S_IDLE) & bus.start_i);

endmodule

// File: tb/tb_absorb_controller.sv
// Directed bench for absorb_controller: a reference walk of each message fills a scoreboard
// of expected words, which a negedge monitor pops on every word transfer.
module tb_absorb_controller;

  logic clk;
  logic rst_n;

  absorb_if #(.LEN_WIDTH(32), .RVB_WIDTH(4)) ifc ();

  absorb_controller #(
    .LEN_WIDTH    (32),
    .RATE128_WORDS(21),
    .RATE256_WORDS(17),
    .W_BYTE_SIZE  (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  typedef struct {
    logic [3:0] rvb;
    logic       pe;
    logic       last;
    logic       cons;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_xfer   = 0;
  int   n_in_hs  = 0;
  int   n_perm   = 0;
  int   n_done   = 0;
  int   exp_blocks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference walk of one message; the expected words go onto the scoreboard.
  task automatic push_expected(input logic mode, input int len, output int blocks, output int ins);
    int  rate;
    int  r;
    int  cnt;
    int  rvb;
    bit  pad;
    exp_t e;
    rate   = mode ? 17 : 21;
    r      = len;
    cnt    = 0;
    pad    = 0;
    blocks = 0;
    ins    = 0;
    for (int k = 0; k < 2000; k++) begin
      rvb    = (r < 8) ? r : 8;
      e.rvb  = 4'(rvb);
      e.pe   = (r < 8);
      e.last = (cnt == rate - 1);
      e.cons = (r != 0);
      sb.push_back(e);
      if (r != 0) ins++;
      r = r - rvb;
      if (e.pe) pad = 1;
      if (e.last) begin
        cnt = 0;
        blocks++;
        if (pad) break;
      end else begin
        cnt++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.in_valid_i && ifc.in_ready_o) n_in_hs++;
      if (ifc.done_o) n_done++;
      if (ifc.perm_start_o) n_perm++;
      if (ifc.word_valid_o && ifc.word_ready_i) begin
        n_xfer++;
        if (sb.size() == 0) begin
          chk("unexpected_word", 32'(ifc.word_valid_o), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rvb", 32'(ifc.remaining_valid_bytes_o), 32'(e.rvb));
          chk("pad_en", 32'(ifc.padding_enable_o), 32'(e.pe));
          chk("last_word", 32'(ifc.last_word_in_block_o), 32'(e.last));
          chk("consume", 32'(ifc.in_valid_i & ifc.in_ready_o), 32'(e.cons));
          chk("perm_start", 32'(ifc.perm_start_o), 32'(e.last));
        end
      end
    end
  end

  // Permutation model: done pulse three cycles after start; done_o must follow the final one.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ifc.perm_start_o) begin
        repeat (3) @(posedge clk);
        #1 ifc.perm_done_i = 1'b1;
        @(posedge clk);
        #1 ifc.perm_done_i = 1'b0;
        @(negedge clk);
        chk("done_after_perm", 32'(ifc.done_o), 32'(n_perm == exp_blocks));
      end
    end
  end

  task automatic run_msg(input logic mode, input int len, input bit toggle, input bit poke_start);
    int blocks;
    int ins;
    push_expected(mode, len, blocks, ins);
    exp_blocks = blocks;
    n_done  = 0;
    n_perm  = 0;
    n_in_hs = 0;
    n_xfer  = 0;
    @(posedge clk);
    #1;
    ifc.start_i   = 1'b1;
    ifc.mode_i    = mode;
    ifc.msg_len_i = 32'(len);
    @(posedge clk);
    #1;
    ifc.start_i   = 1'b0;
    ifc.msg_len_i = 32'h0000_FFFF;
    ifc.mode_i    = ~mode;
    chk("busy_after_start", 32'(ifc.busy_o), 32'd1);
    for (int c = 0; c < 3000 && n_done == 0; c++) begin
      ifc.in_valid_i   = toggle ? c[0] : 1'b1;
      ifc.word_ready_i = toggle ? !(c >= 2 && c <= 4) : 1'b1;
      ifc.start_i      = poke_start && (c == 5);
      @(posedge clk);
      #1;
    end
    ifc.start_i = 1'b0;
    chk("done_seen", 32'(n_done != 0), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("done_count", 32'(n_done), 32'd1);
    chk("perm_count", 32'(n_perm), 32'(blocks));
    chk("inputs_consumed", 32'(n_in_hs), 32'(ins));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("idle_after_done", 32'(ifc.busy_o), 32'd0);
    sb.delete();
  endtask

  initial begin
    int blocks;
    int ins;
    rst_n            = 1'b0;
    ifc.start_i      = 1'b0;
    ifc.mode_i       = 1'b0;
    ifc.msg_len_i    = '0;
    ifc.in_valid_i   = 1'b0;
    ifc.word_ready_i = 1'b0;
    ifc.perm_done_i  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_padding_reset", 32'(ifc.padding_reset_o), 32'd1);
    chk("rst_busy", 32'(ifc.busy_o), 32'd0);
    chk("rst_word_valid", 32'(ifc.word_valid_o), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready_o), 32'd0);
    chk("rst_done", 32'(ifc.done_o), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_padding_reset", 32'(ifc.padding_reset_o), 32'd0);
    chk("idle_busy", 32'(ifc.busy_o), 32'd0);

    run_msg(1'b1, 5, 1'b0, 1'b1);
    run_msg(1'b0, 168, 1'b0, 1'b0);
    run_msg(1'b1, 0, 1'b0, 1'b0);
    run_msg(1'b0, 16, 1'b1, 1'b0);

    // Abort a two-block message with reset while word 7 is on the bus.
    push_expected(1'b0, 200, blocks, ins);
    exp_blocks = blocks;
    n_done = 0;
    n_perm = 0;
    n_xfer = 0;
    @(posedge clk);
    #1;
    ifc.start_i      = 1'b1;
    ifc.mode_i       = 1'b0;
    ifc.msg_len_i    = 32'd200;
    ifc.in_valid_i   = 1'b1;
    ifc.word_ready_i = 1'b1;
    @(posedge clk);
    #1 ifc.start_i = 1'b0;
    for (int c = 0; c < 200 && n_xfer < 7; c++) begin
      @(posedge clk);
      #1;
    end
    chk("reached_word7", 32'(n_xfer), 32'd7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_padding_reset", 32'(ifc.padding_reset_o), 32'd1);
    chk("abort_word_valid", 32'(ifc.word_valid_o), 32'd0);
    chk("abort_in_ready", 32'(ifc.in_ready_o), 32'd0);
    chk("abort_busy", 32'(ifc.busy_o), 32'd0);
    chk("abort_rvb", 32'(ifc.remaining_valid_bytes_o), 32'd0);
    chk("abort_pad_en", 32'(ifc.padding_enable_o), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    repeat (30) @(posedge clk);
    #1;
    chk("abort_idle", 32'(ifc.busy_o), 32'd0);
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_no_perm", 32'(n_perm), 32'd0);
    chk("abort_no_words", 32'(ifc.word_valid_o), 32'd0);

    run_msg(1'b0, 200, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/absorb_controller.md
Name: absorb_controller

Overview:
- Sequences the SHAKE absorb phase: walks a byte-length message through the padding generator one w-bit word at a time, counts words per rate block, and hands each completed block to the Keccak permutation.
- Drives the padding generator's control inputs: remaining_valid_bytes, padding_enable, last_word_in_block and padding_reset.
- Emits padding-only words without consuming input.
- Sits between the message input stream and the padding_generator/state-XOR path, and handshakes with the permutation core.

Parameters:
- LEN_WIDTH, 32, width of the message byte-length input.
- RATE128_WORDS, 21, words per block for SHAKE128 (1344-bit rate).
- RATE256_WORDS, 17, words per block for SHAKE256 (1088-bit rate).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- start_i  in  1  begin a message; sampled only in IDLE.
- mode_i  in  1  0=SHAKE128, 1=SHAKE256; latched on start.
- msg_len_i  in  LEN_WIDTH  message length in bytes; latched on start.
- in_valid_i  in  1  message word valid.
- in_ready_o  out  1  message word accepted when in_valid_i&in_ready_o.
- word_valid_o  out  1  padded word presented to the state-XOR path.
- word_ready_i  in  1  state-XOR path accepts the word.
- remaining_valid_bytes_o  out  w_byte_width+1  valid message bytes in the current word, to padding_generator.
- padding_enable_o  out  1  to padding_generator.
- last_word_in_block_o  out  1  to padding_generator.
- padding_reset_o  out  1  to padding_generator.
- perm_start_o  out  1  one-cycle pulse to start the permutation.
- perm_done_i  in  1  permutation complete (single-cycle pulse).
- busy_o  out  1  high outside IDLE.
- done_o  out  1  one-cycle pulse when the final block's permutation completes.

Behaviour:
- Registers:
  - state (IDLE, ABSORB, PERMUTE, FINISH).
  - R: remaining bytes, LEN_WIDTH bits.
  - word_cnt: 0..rate-1.
  - rate_sel.
  - pad_started: padding has been applied.
- Reset (rst_n low at a clock edge):
  - state=IDLE, R=0, word_cnt=0, pad_started=0.
  - All outputs are 0 except padding_reset_o, which is 1 while rst_n is low.
  - Reset mid-message aborts immediately, with no done_o.
- IDLE:
  - On start_i, latch msg_len_i into R and mode_i into rate_sel, clear word_cnt and pad_started, then go to ABSORB.
  - padding_reset_o = !rst_n | (IDLE & start_i).
  - start_i outside IDLE is ignored.
- ABSORB, per-word control (combinational from registers):
  - need_input = (R != 0).
  - remaining_valid_bytes_o = min(R, w_byte_size).
  - padding_enable_o = (R < w_byte_size), i.e. it stays high for every word after the message is exhausted.
  - last_word_in_block_o = (word_cnt == rate-1).
  - word_valid_o = need_input ? in_valid_i : 1.
  - in_ready_o = need_input & word_ready_i.
- Transfer (word_valid_o & word_ready_i):
  - R <= R - remaining_valid_bytes_o, saturating at 0.
  - If padding_enable_o, pad_started <= 1.
  - If last_word_in_block_o: word_cnt <= 0, perm_start_o pulses in that same cycle, and state goes to PERMUTE. Otherwise word_cnt increments.
- Without a transfer, all registers hold; stalls may last any number of cycles on either side.
- PERMUTE:
  - word_valid_o=0, in_ready_o=0, and padding outputs are 0.
  - On perm_done_i: go to FINISH if pad_started, else back to ABSORB.
- FINISH: done_o=1 for one cycle, then IDLE.
- Padding is always emitted, including for zero-length messages. This satisfies the padding_generator contract that the first word with padding_enable carries the domain separator and the block's last word carries 0x80.
- Boundary: if R is an exact multiple of the block size, the final message word closes a block with padding_enable_o=0. An extra all-padding block follows (first word R=0, padding_enable_o=1).
- Boundary: if R mod 8 = 0, the first padding word carries 0 valid bytes.
- Latency: one transfer per cycle at most; one cycle from perm_done_i to the first word of the next block.

Test Plan:
- SHAKE256, msg_len=5 -> one block of 17 word transfers:
  - word0: remaining_valid_bytes=5, padding_enable=1, 1 input word consumed.
  - words 1..16: no input consumed, padding_enable=1.
  - word16: last_word_in_block=1.
  - perm_start pulse; done_o one cycle after perm_done_i.
- SHAKE128, msg_len=168 (exactly one block) -> 21 words with padding_enable=0 and 21 inputs consumed, then a second block of 21 pad-only words (first with remaining_valid_bytes=0), then 2 perm_start pulses and 1 done_o.
- SHAKE256, msg_len=0 -> 17 pad words, zero in_ready_o&in_valid_i handshakes, done_o after one permutation.
- SHAKE128, msg_len=16 with in_valid_i toggling every cycle and word_ready_i low for 3 cycles -> exactly 2 inputs consumed, no word duplicated or lost, and the third word has remaining_valid_bytes=0 and padding_enable=1.
- rst_n low for 1 cycle during word 7 of a 2-block message -> IDLE, all outputs 0 except padding_reset_o=1 during reset, no done_o. A new start_i runs to completion normally.
- start_i asserted while busy -> ignored; msg_len_i/mode_i changes mid-message do not affect word counts.
